// File: rtl/controller_sequencer.sv
// SAP-1 style controller/sequencer: a one-hot T1..T6 ring clocked on the falling edge
// drives a combinational 12-bit control word. Define SAP_HLT_EN to enable the HLT opcode.
module controller_sequencer #(
  parameter int OP_WIDTH  = 4,
  parameter int CON_WIDTH = 12
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [OP_WIDTH-1:0]  OPCODE,
  output logic [CON_WIDTH-1:0] CON,
  output logic [5:0]           T_STATE,
  output logic                 HLT
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Control word bit order: {CP,EP,LM_N,CE_N,LI_N,EI_N,LA_N,EA,SU,EU,LB_N,LO_N}
  localparam logic [CON_WIDTH-1:0] W_IDLE    = CON_WIDTH'(12'h3E3);
  localparam logic [CON_WIDTH-1:0] W_FETCH1  = CON_WIDTH'(12'h5E3);
  localparam logic [CON_WIDTH-1:0] W_FETCH2  = CON_WIDTH'(12'hBE3);
  localparam logic [CON_WIDTH-1:0] W_FETCH3  = CON_WIDTH'(12'h263);
  localparam logic [CON_WIDTH-1:0] W_LM_EI   = CON_WIDTH'(12'h1A3);
  localparam logic [CON_WIDTH-1:0] W_CE_LA   = CON_WIDTH'(12'h2C3);
  localparam logic [CON_WIDTH-1:0] W_CE_LB   = CON_WIDTH'(12'h2E1);
  localparam logic [CON_WIDTH-1:0] W_ADD     = CON_WIDTH'(12'h3C7);
  localparam logic [CON_WIDTH-1:0] W_SUB     = CON_WIDTH'(12'h3CF);
  localparam logic [CON_WIDTH-1:0] W_OUT     = CON_WIDTH'(12'h3F2);

  localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(4'b0000);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0001);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0010);
  localparam logic [OP_WIDTH-1:0] OP_OUT = OP_WIDTH'(4'b1110);

  t_state_e               r_state;
  t_state_e               w_state_next;
  logic                   w_halt;
  logic [CON_WIDTH-1:0]   w_con;

`ifdef SAP_HLT_EN
  localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(4'b1111);

  logic r_hlt;
  logic w_hlt_req;

  assign w_hlt_req = (r_state == T4) && (OPCODE == OP_HLT);

  // Once latched, halt no longer depends on OPCODE; only CLR releases it.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      r_hlt <= 1'b0;
    end else if (w_hlt_req) begin
      r_hlt <= 1'b1;
    end
  end

  assign w_halt = r_hlt | w_hlt_req;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= T1;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = T1;
    if (w_halt) begin
      w_state_next = r_state;
    end else begin
      case (r_state)
        T1:      w_state_next = T2;
        T2:      w_state_next = T3;
        T3:      w_state_next = T4;
        T4:      w_state_next = T5;
        T5:      w_state_next = T6;
        T6:      w_state_next = T1;
        default: w_state_next = T1;
      endcase
    end
  end

  always_comb begin
    w_con = W_IDLE;
    case (r_state)
      T1: w_con = W_FETCH1;
      T2: w_con = W_FETCH2;
      T3: w_con = W_FETCH3;
      T4: begin
        if (OPCODE == OP_LDA || OPCODE == OP_ADD || OPCODE == OP_SUB) begin
          w_con = W_LM_EI;
        end else if (OPCODE == OP_OUT) begin
          w_con = W_OUT;
        end
      end
      T5: begin
        if (OPCODE == OP_LDA) begin
          w_con = W_CE_LA;
        end else if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
          w_con = W_CE_LB;
        end
      end
      T6: begin
        if (OPCODE == OP_ADD) begin
          w_con = W_ADD;
        end else if (OPCODE == OP_SUB) begin
          w_con = W_SUB;
        end
      end
      default: w_con = W_IDLE;
    endcase
    // CLR suppresses the T1 fetch word so no control pulse escapes during reset.
    if (w_halt || CLR) begin
      w_con = W_IDLE;
    end
  end

  assign CON     = w_con;
  assign T_STATE = r_state;
  assign HLT     = w_halt & ~CLR;

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 4, opcode width taken from the instruction register upper nibble.
REQ-002 SHALL have parameter CON_WIDTH, default 12, control-word width (fixed at 12).
REQ-003 CLK  input  1  single system clock; ring counter advances on the falling edge.
REQ-004 CLR  input  1  asynchronous, active-high reset.
REQ-005 OPCODE  input  OP_WIDTH  current instruction opcode, from instruction-register sequencer output.
REQ-006 CON  output  12  control word {CP,EP,LM_N,CE_N,LI_N,EI_N,LA_N,EA,SU,EU,LB_N,LO_N}, bit 11 = CP.
REQ-007 T_STATE  output  6  one-hot ring state, bit0 = T1 ... bit5 = T6.
REQ-008 HLT  output  1  halt indication to clock gating; active high.

Function
REQ-009 Ring counter SHALL be one-hot over T1..T6, advancing T1->T2->...->T6->T1 on each falling CLK edge.
REQ-010 CON SHALL be combinational from T_STATE and OPCODE; inactive word is 12'h3E3.
REQ-011 Fetch, opcode-independent: T1 = 5E3 (EP, LM_N), T2 = BE3 (CP), T3 = 263 (CE_N, LI_N).
REQ-012 LDA (0000): T4 = 1A3, T5 = 2C3, T6 = 3E3.
REQ-013 ADD (0001): T4 = 1A3, T5 = 2E1, T6 = 3C7.
REQ-014 SUB (0010): T4 = 1A3, T5 = 2E1, T6 = 3CF.
REQ-015 OUT (1110): T4 = 3F2, T5 = 3E3, T6 = 3E3.
REQ-016 Any other opcode (and HLT when SAP_HLT_EN is undefined) SHALL produce 3E3 in T4..T6 (NOP).
REQ-017 OPCODE SHALL only be decoded in T4..T6; OPCODE changes during T1..T3 SHALL NOT affect CON.
REQ-018 Exactly one T_STATE bit SHALL be set at all times; an illegal ring value SHALL recover to T1 on the next falling edge.
REQ-019 Every instruction SHALL occupy exactly 6 clock cycles; no early termination.

Reset
REQ-020 CLR high SHALL immediately force T_STATE = 6'b000001, HLT = 0, CON = 3E3, regardless of CLK.
REQ-021 While CLR is high, CON SHALL stay 3E3 (T1 word suppressed); 5E3 SHALL appear only once CLR is low.
REQ-022 CLR deassertion SHALL leave T1 active; the first falling edge afterwards SHALL move to T2.
REQ-023 CLR asserted mid-instruction (any T-state, or halted) SHALL abort the instruction with no further control pulses.

Configuration
REQ-024 Macro SAP_HLT_EN defined: opcode 1111 in T4 SHALL set HLT = 1 and freeze the ring at T4 with CON = 3E3 until CLR.
REQ-025 SAP_HLT_EN undefined: HLT SHALL be tied to 0; opcode 1111 SHALL behave as NOP per REQ-016.

Verification
REQ-026 CLR pulse mid-T5 of ADD -> T_STATE = 000001 and CON = 3E3 asynchronously; after release, CON = 5E3.
REQ-027 OPCODE = 0000, run 6 falling edges from T1 -> CON sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to 5E3.
REQ-028 OPCODE = 0010 -> T4..T6 = 1A3, 2E1, 3CF; OPCODE = 0001 -> T6 = 3C7 (SU clear).
REQ-029 OPCODE = 1110 -> T4 = 3F2, T5/T6 = 3E3; OPCODE = 0101 -> T4..T6 all 3E3.
REQ-030 SAP_HLT_EN defined, OPCODE = 1111 -> HLT = 1 at T4 and T_STATE held at 001000 for 20 edges; CLR -> HLT = 0, T1. Undefined -> HLT stays 0, ring keeps cycling.
REQ-031 OPCODE toggled randomly during T1..T3 -> fetch words unchanged (5E3, BE3, 263); one-hot checked every cycle.
